// File: rtl/caption_draw.sv
// Caption overlay stage: maps the pixel position to a caption ROM address and
// paints set ROM bits in a solid colour, with show/blink control on frame count.
module caption_draw #(
   parameter int unsigned XPOS         = 148,
   parameter int unsigned YPOS         = 268,
   parameter int unsigned WIDTH        = 344,
   parameter int unsigned HEIGHT       = 64,
   parameter logic [11:0] COLOR        = 12'hFF0,
   parameter int unsigned BLINK_FRAMES = 30
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [10:0] hcount_in,
   input  logic [10:0] vcount_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        hblnk_in,
   input  logic        vblnk_in,
   input  logic [11:0] rgb_in,
   input  logic        show,
   input  logic        blink,
   input  logic        pixel_bit,
   output logic [14:0] address,
   output logic [10:0] hcount_out,
   output logic [10:0] vcount_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        hblnk_out,
   output logic        vblnk_out,
   output logic [11:0] rgb_out
);

   localparam int unsigned CW   = 12;
   localparam int unsigned AW   = 15;
   localparam int unsigned CNTW = 8;

   localparam logic [CW-1:0]   X_LO     = CW'(XPOS);
   localparam logic [CW-1:0]   X_HI     = CW'(XPOS + WIDTH);
   localparam logic [CW-1:0]   Y_LO     = CW'(YPOS);
   localparam logic [CW-1:0]   Y_HI     = CW'(YPOS + HEIGHT);
   localparam logic [AW-1:0]   STRIDE   = AW'(WIDTH);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BLINK_FRAMES - 1);

   typedef enum logic [1:0] {
      ST_HIDDEN = 2'd0,
      ST_ON     = 2'd1,
      ST_OFF    = 2'd2
   } state_t;

   state_t          state_q, state_n;
   logic [CNTW-1:0] cnt_q, cnt_n;
   logic            vblnk_prev_q;
   logic            frame_tick_c;

   logic [CW-1:0] h_ext_c, v_ext_c;
   logic          in_win_c;
   logic [AW-1:0] col_c, row_c, addr_c;

   logic          in_win_d1;
   logic [10:0]   hcount_d1, vcount_d1;
   logic          hsync_d1, vsync_d1, hblnk_d1, vblnk_d1;
   logic [11:0]   rgb_d1;
   logic [11:0]   rgb_c;

   // Window test and row-major address, all in 12-bit unsigned
   always_comb begin
      h_ext_c  = CW'(hcount_in);
      v_ext_c  = CW'(vcount_in);
      in_win_c = (h_ext_c >= X_LO) && (h_ext_c < X_HI) &&
                 (v_ext_c >= Y_LO) && (v_ext_c < Y_HI);
      col_c    = AW'(h_ext_c - X_LO);
      row_c    = AW'(v_ext_c - Y_LO);
      addr_c   = in_win_c ? AW'(row_c * STRIDE + col_c) : '0;
   end

   assign frame_tick_c = vblnk_in & ~vblnk_prev_q;

   // Show/blink state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_HIDDEN;
         cnt_q        <= '0;
         vblnk_prev_q <= 1'b0;
      end else begin
         state_q      <= state_n;
         cnt_q        <= cnt_n;
         vblnk_prev_q <= vblnk_in;
      end
   end

   // Next state: a show drop wins over any frame tick in the same cycle
   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      unique case (state_q)
         ST_HIDDEN: begin
            cnt_n = '0;
            if (show) state_n = ST_ON;
         end
         ST_ON: begin
            if (!show) begin
               state_n = ST_HIDDEN;
            end else if (blink && frame_tick_c) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_n   = '0;
                  state_n = ST_OFF;
               end else begin
                  cnt_n = cnt_q + CNTW'(1);
               end
            end
         end
         ST_OFF: begin
            if (!show) begin
               state_n = ST_HIDDEN;
            end else if (!blink) begin
               cnt_n   = '0;
               state_n = ST_ON;
            end else if (frame_tick_c) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_n   = '0;
                  state_n = ST_ON;
               end else begin
                  cnt_n = cnt_q + CNTW'(1);
               end
            end
         end
         default: begin
            state_n = ST_HIDDEN;
            cnt_n   = '0;
         end
      endcase
   end

   // Stage-2 colour select; blanking always passes the upstream colour
   always_comb begin
      rgb_c = rgb_d1;
      if (!(hblnk_d1 || vblnk_d1) && in_win_d1 && pixel_bit && (state_q == ST_ON))
         rgb_c = COLOR;
   end

   // Two-stage pixel pipeline
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         address    <= '0;
         in_win_d1  <= 1'b0;
         hcount_d1  <= '0;
         vcount_d1  <= '0;
         hsync_d1   <= 1'b0;
         vsync_d1   <= 1'b0;
         hblnk_d1   <= 1'b0;
         vblnk_d1   <= 1'b0;
         rgb_d1     <= '0;
         hcount_out <= '0;
         vcount_out <= '0;
         hsync_out  <= 1'b0;
         vsync_out  <= 1'b0;
         hblnk_out  <= 1'b0;
         vblnk_out  <= 1'b0;
         rgb_out    <= '0;
      end else begin
         address    <= addr_c;
         in_win_d1  <= in_win_c;
         hcount_d1  <= hcount_in;
         vcount_d1  <= vcount_in;
         hsync_d1   <= hsync_in;
         vsync_d1   <= vsync_in;
         hblnk_d1   <= hblnk_in;
         vblnk_d1   <= vblnk_in;
         rgb_d1     <= rgb_in;
         hcount_out <= hcount_d1;
         vcount_out <= vcount_d1;
         hsync_out  <= hsync_d1;
         vsync_out  <= vsync_d1;
         hblnk_out  <= hblnk_d1;
         vblnk_out  <= vblnk_d1;
         rgb_out    <= rgb_c;
      end
   end

endmodule

// File: tb/tb_caption_draw.sv
// Directed bench for caption_draw: steady-state vector table plus hand
// sequences for latency, blinking, show drop and asynchronous reset.
module tb_caption_draw;

   localparam int unsigned BF = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [10:0] hcount_in, vcount_in;
   logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
   logic [11:0] rgb_in;
   logic        show, blink, pixel_bit;
   logic [14:0] address;
   logic [10:0] hcount_out, vcount_out;
   logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
   logic [11:0] rgb_out;

   int checks = 0;
   int errors = 0;

   caption_draw #(
      .XPOS(148), .YPOS(268), .WIDTH(344), .HEIGHT(64),
      .COLOR(12'hFF0), .BLINK_FRAMES(BF)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .hcount_in(hcount_in), .vcount_in(vcount_in),
      .hsync_in(hsync_in), .vsync_in(vsync_in),
      .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
      .rgb_in(rgb_in), .show(show), .blink(blink), .pixel_bit(pixel_bit),
      .address(address),
      .hcount_out(hcount_out), .vcount_out(vcount_out),
      .hsync_out(hsync_out), .vsync_out(vsync_out),
      .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
      .rgb_out(rgb_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        show;
      logic [10:0] h;
      logic [10:0] v;
      logic [11:0] rgb;
      logic        hb;
      logic        vb;
      logic        pb;
      logic [14:0] exp_addr;
      logic [11:0] exp_rgb;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One frame tick, then let the pipeline settle on unblanked pixels
   task automatic do_tick();
      @(negedge clk) vblnk_in = 1'b1;
      @(negedge clk) vblnk_in = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic chk_vis(input string nm, input logic vis);
      chk(nm, 32'(rgb_out), vis ? 32'h0FF0 : 32'h0321);
   endtask

   initial begin
      logic exp_vis[5];

      //          show  h      v      rgb      hb    vb    pb    addr      rgb_out
      vecs[0]  = '{1'b0, 11'd10,  11'd10,  12'h123, 1'b0, 1'b0, 1'b0, 15'd0,     12'h123};
      vecs[1]  = '{1'b0, 11'd148, 11'd268, 12'h456, 1'b0, 1'b0, 1'b1, 15'd0,     12'h456};
      vecs[2]  = '{1'b1, 11'd148, 11'd268, 12'h456, 1'b0, 1'b0, 1'b1, 15'd0,     12'hFF0};
      vecs[3]  = '{1'b1, 11'd491, 11'd331, 12'h0AB, 1'b0, 1'b0, 1'b1, 15'd22015, 12'hFF0};
      vecs[4]  = '{1'b1, 11'd492, 11'd331, 12'h0AB, 1'b0, 1'b0, 1'b1, 15'd0,     12'h0AB};
      vecs[5]  = '{1'b1, 11'd491, 11'd332, 12'h0CD, 1'b0, 1'b0, 1'b1, 15'd0,     12'h0CD};
      vecs[6]  = '{1'b1, 11'd147, 11'd300, 12'h0EF, 1'b0, 1'b0, 1'b1, 15'd0,     12'h0EF};
      vecs[7]  = '{1'b1, 11'd148, 11'd267, 12'h111, 1'b0, 1'b0, 1'b1, 15'd0,     12'h111};
      vecs[8]  = '{1'b1, 11'd200, 11'd300, 12'h321, 1'b0, 1'b0, 1'b0, 15'd11060, 12'h321};
      vecs[9]  = '{1'b1, 11'd200, 11'd300, 12'h321, 1'b1, 1'b0, 1'b1, 15'd11060, 12'h321};
      vecs[10] = '{1'b1, 11'd200, 11'd300, 12'h321, 1'b0, 1'b1, 1'b1, 15'd11060, 12'h321};
      vecs[11] = '{1'b1, 11'd200, 11'd300, 12'h321, 1'b0, 1'b0, 1'b1, 15'd11060, 12'hFF0};
      vecs[12] = '{1'b1, 11'd2047, 11'd2047, 12'h777, 1'b0, 1'b0, 1'b1, 15'd0,    12'h777};
      vecs[13] = '{1'b0, 11'd10,  11'd10,  12'h123, 1'b0, 1'b0, 1'b1, 15'd0,     12'h123};

      // Reset with busy inputs: everything must read zero
      rst_n = 1'b0;
      hcount_in = 11'd200; vcount_in = 11'd300; rgb_in = 12'hFFF;
      hsync_in = 1'b1; vsync_in = 1'b1; hblnk_in = 1'b0; vblnk_in = 1'b0;
      show = 1'b1; blink = 1'b0; pixel_bit = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset address", 32'(address), 32'd0);
      chk("reset rgb_out", 32'(rgb_out), 32'd0);
      chk("reset hcount_out", 32'(hcount_out), 32'd0);
      chk("reset hsync_out", 32'(hsync_out), 32'd0);
      show = 1'b0;
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         show = vecs[i].show; hcount_in = vecs[i].h; vcount_in = vecs[i].v;
         rgb_in = vecs[i].rgb; hblnk_in = vecs[i].hb; vblnk_in = vecs[i].vb;
         pixel_bit = vecs[i].pb; hsync_in = i[0]; vsync_in = i[1];
         repeat (2) @(negedge clk);
         chk($sformatf("vec%0d address", i), 32'(address), 32'(vecs[i].exp_addr));
         chk($sformatf("vec%0d rgb_out", i), 32'(rgb_out), 32'(vecs[i].exp_rgb));
         chk($sformatf("vec%0d hcount_out", i), 32'(hcount_out), 32'(vecs[i].h));
         chk($sformatf("vec%0d vcount_out", i), 32'(vcount_out), 32'(vecs[i].v));
         chk($sformatf("vec%0d blanks", i), 32'({hblnk_out, vblnk_out}),
             32'({vecs[i].hb, vecs[i].vb}));
         chk($sformatf("vec%0d syncs", i), 32'({hsync_out, vsync_out}), 32'({i[0], i[1]}));
      end

      // Exactly two clocks of latency
      @(negedge clk);
      hcount_in = 11'd20; vcount_in = 11'd21; rgb_in = 12'hABC; hsync_in = 1'b1;
      pixel_bit = 1'b0;
      @(negedge clk);
      chk("lat1 rgb_out", 32'(rgb_out), 32'h123);
      chk("lat1 hcount_out", 32'(hcount_out), 32'd10);
      @(negedge clk);
      chk("lat2 rgb_out", 32'(rgb_out), 32'hABC);
      chk("lat2 hcount_out", 32'(hcount_out), 32'd20);
      chk("lat2 vcount_out", 32'(vcount_out), 32'd21);
      chk("lat2 hsync_out", 32'(hsync_out), 32'd1);

      // Blink with BLINK_FRAMES=2
      @(negedge clk);
      show = 1'b1; blink = 1'b0; hcount_in = 11'd200; vcount_in = 11'd300;
      rgb_in = 12'h321; pixel_bit = 1'b1; hblnk_in = 1'b0; vblnk_in = 1'b0;
      repeat (3) @(negedge clk);
      blink = 1'b1;
      exp_vis = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      repeat (2) @(negedge clk);
      chk_vis("blink tick0", exp_vis[0]);
      for (int t = 1; t < 5; t++) begin
         do_tick();
         chk_vis($sformatf("blink tick%0d", t), exp_vis[t]);
      end
      do_tick();
      chk_vis("blink tick5", 1'b1);
      do_tick();
      chk_vis("blink tick6", 1'b0);

      // show drop coincident with a frame tick while OFF
      @(negedge clk) begin show = 1'b0; vblnk_in = 1'b1; end
      @(negedge clk) vblnk_in = 1'b0;
      repeat (3) @(negedge clk);
      chk_vis("drop hidden", 1'b0);
      @(negedge clk) show = 1'b1;
      repeat (3) @(negedge clk);
      chk_vis("reshow on", 1'b1);
      do_tick();
      chk_vis("reshow tick1", 1'b1);
      do_tick();
      chk_vis("reshow tick2", 1'b0);
      @(negedge clk) blink = 1'b0;
      repeat (3) @(negedge clk);
      chk_vis("blink off on", 1'b1);

      // Into OFF, then asynchronous reset between edges
      @(negedge clk) blink = 1'b1;
      do_tick();
      do_tick();
      chk_vis("pre-reset off", 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async rgb_out", 32'(rgb_out), 32'd0);
      chk("async address", 32'(address), 32'd0);
      chk("async hcount_out", 32'(hcount_out), 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("post-reset1 address", 32'(address), 32'd11060);
      chk("post-reset1 rgb_out", 32'(rgb_out), 32'd0);
      @(negedge clk);
      chk_vis("post-reset2 restart", 1'b1);
      chk("post-reset2 hcount_out", 32'(hcount_out), 32'd200);
      do_tick();
      chk_vis("post-reset tick1", 1'b1);
      do_tick();
      chk_vis("post-reset tick2", 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
